// File: rtl/ets_cmp_window_accumulator.sv
// ---------------------------------------------------------------------------
// ets_cmp_window_accumulator
//
// Equivalent-time-sampling hit counter for the comparator path. On each start
// request the block waits a settle interval, counts comparator '1' samples
// over a 2^W-cycle window, and presents the count to the MCU over a
// valid/ready handshake. The MCU steps the MMCM phase between windows and
// rebuilds the waveform from successive counts.
//
// Optional feature: define ETS_CMP_DEGLITCH_EN to pass cmp_in through a 3-tap
// majority filter before accumulation. Sampling, and therefore res_valid,
// move two cycles later. The taps are cleared on reset only.
//
// Ports
//   shifting_clk    in   phase-shifted sample clock, all logic runs on it
//   free_run_rst_n  in   asynchronous active-low reset
//   cmp_in          in   registered comparator bit (already synchronous)
//   start           in   single-cycle measurement request
//   settle_cycles   in   [15:0] cycles to skip after start (latched)
//   win_log2        in   [4:0] window exponent W (latched, clamped)
//   busy            out  high whenever the FSM is not idle
//   res_valid       out  result available
//   res_ready       in   consumer accepts the result
//   res_ones        out  [CNT_W-1:0] count of '1' samples in the window
//   res_win_log2    out  [4:0] window exponent actually used
//   res_seq         out  [SEQ_W-1:0] result tag, +1 per delivered result
//   overrun         out  pulse when start arrives while busy (start ignored)
// ---------------------------------------------------------------------------
module ets_cmp_window_accumulator #(
   parameter int MAX_WIN_LOG2 = 16,
   parameter int CNT_W        = MAX_WIN_LOG2 + 1,
   parameter int SEQ_W        = 8
) (
   input  logic               shifting_clk,
   input  logic               free_run_rst_n,
   input  logic               cmp_in,
   input  logic               start,
   input  logic [15:0]        settle_cycles,
   input  logic [4:0]         win_log2,
   output logic               busy,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [CNT_W-1:0]   res_ones,
   output logic [4:0]         res_win_log2,
   output logic [SEQ_W-1:0]   res_seq,
   output logic               overrun
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      ACCUM  = 2'd2,
      HOLD   = 2'd3
   } state_t;

   localparam logic [4:0] MAX_W = 5'(MAX_WIN_LOG2);

   state_t             state_reg;
   state_t             state_next;
   logic [16:0]        settle_cnt_reg;
   logic [CNT_W-1:0]   win_cnt_reg;
   logic [CNT_W-1:0]   acc_reg;
   logic [4:0]         w_reg;
   logic [SEQ_W-1:0]   seq_reg;

   logic               sample_bit;
   logic [4:0]         w_clamped;
   logic [16:0]        settle_load;
   logic [CNT_W-1:0]   win_load;

`ifdef ETS_CMP_DEGLITCH_EN
   // The filter output at cycle k depends on cmp_in at k-2..k, so the
   // settle phase is stretched by two cycles to line the window up with
   // fully populated taps.
   localparam logic [16:0] PIPE_DLY = 17'd2;

   logic [1:0] tap_reg;

   always_ff @(posedge shifting_clk or negedge free_run_rst_n) begin
      if (!free_run_rst_n) begin
         tap_reg <= 2'b00;
      end else begin
         tap_reg <= {tap_reg[0], cmp_in};
      end
   end

   assign sample_bit = (cmp_in & tap_reg[0]) | (cmp_in & tap_reg[1]) |
                       (tap_reg[0] & tap_reg[1]);
`else
   localparam logic [16:0] PIPE_DLY = 17'd0;

   assign sample_bit = cmp_in;
`endif

   assign w_clamped   = (win_log2 > MAX_W) ? MAX_W : win_log2;
   // 17-bit so the deglitch extension cannot wrap a maximal settle value.
   assign settle_load = {1'b0, settle_cycles} + PIPE_DLY;
   // Window counter holds "samples remaining minus one".
   assign win_load    = (CNT_W'(1) << w_clamped) - CNT_W'(1);

   // State register
   always_ff @(posedge shifting_clk or negedge free_run_rst_n) begin
      if (!free_run_rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next state and status outputs
   always_comb begin
      state_next = state_reg;
      busy       = 1'b0;
      res_valid  = 1'b0;
      overrun    = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = (settle_load != 17'd0) ? SETTLE : ACCUM;
            end
         end
         SETTLE: begin
            busy = 1'b1;
            if (settle_cnt_reg == 17'd1) begin
               state_next = ACCUM;
            end
         end
         ACCUM: begin
            busy = 1'b1;
            if (win_cnt_reg == '0) begin
               state_next = HOLD;
            end
         end
         HOLD: begin
            busy      = 1'b1;
            res_valid = 1'b1;
            if (res_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // A start coinciding with the HOLD handshake is still seen as busy.
      overrun = start & busy;
   end

   // Datapath
   always_ff @(posedge shifting_clk or negedge free_run_rst_n) begin
      if (!free_run_rst_n) begin
         settle_cnt_reg <= '0;
         win_cnt_reg    <= '0;
         acc_reg        <= '0;
         w_reg          <= '0;
         seq_reg        <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  settle_cnt_reg <= settle_load;
                  win_cnt_reg    <= win_load;
                  acc_reg        <= '0;
                  w_reg          <= w_clamped;
               end
            end
            SETTLE: begin
               settle_cnt_reg <= settle_cnt_reg - 17'd1;
            end
            ACCUM: begin
               // At most 2^MAX_WIN_LOG2 increments, which CNT_W holds.
               acc_reg     <= acc_reg + CNT_W'(sample_bit);
               win_cnt_reg <= win_cnt_reg - CNT_W'(1);
            end
            HOLD: begin
               if (res_ready) begin
                  seq_reg <= seq_reg + SEQ_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Result fields are only written in IDLE/ACCUM, so they hold in HOLD.
   assign res_ones     = acc_reg;
   assign res_win_log2 = w_reg;
   assign res_seq      = seq_reg;

endmodule

// File: tb/tb_ets_cmp_window_accumulator.sv
// ---------------------------------------------------------------------------
// tb_ets_cmp_window_accumulator
//
// Directed scenarios with hand-computed literal expectations, followed by a
// randomized run. A cycle-indexed reference model (start cycle, latched S/W,
// recorded comparator history) predicts every output on every cycle.
// ---------------------------------------------------------------------------
module tb_ets_cmp_window_accumulator;

   localparam int MAXW = 5;
   localparam int CW   = MAXW + 1;
   localparam int SW   = 8;
`ifdef ETS_CMP_DEGLITCH_EN
   localparam int D = 2;
`else
   localparam int D = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmp_in;
   logic          start;
   logic [15:0]   settle_cycles;
   logic [4:0]    win_log2;
   logic          busy;
   logic          res_valid;
   logic          res_ready;
   logic [CW-1:0] res_ones;
   logic [4:0]    res_win_log2;
   logic [SW-1:0] res_seq;
   logic          overrun;

   ets_cmp_window_accumulator #(
      .MAX_WIN_LOG2 (MAXW),
      .CNT_W        (CW),
      .SEQ_W        (SW)
   ) dut (
      .shifting_clk   (clk),
      .free_run_rst_n (rst_n),
      .cmp_in         (cmp_in),
      .start          (start),
      .settle_cycles  (settle_cycles),
      .win_log2       (win_log2),
      .busy           (busy),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_ones       (res_ones),
      .res_win_log2   (res_win_log2),
      .res_seq        (res_seq),
      .overrun        (overrun)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int cyc       = 0;
   bit hist [0:65535];
   int rst_cycle = 0;
   bit have_prev = 1'b0;
   bit m_busy    = 1'b0;
   int m_t0      = 0;
   int m_S       = 0;
   int m_W       = 0;
   int m_seq     = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, act, exp);
      end
   endtask

   // Comparator value seen at cycle j; anything before the last reset is 0.
   function automatic int h(input int j);
      if (j < 0 || j < rst_cycle) return 0;
      return int'(hist[j]);
   endfunction

   function automatic int smp(input int k);
      if (D != 0) return ((h(k) + h(k-1) + h(k-2)) >= 2) ? 1 : 0;
      return h(k);
   endfunction

   function automatic bit exp_valid();
      return m_busy && (cyc >= m_t0 + D + m_S + (1 << m_W) + 1);
   endfunction

   function automatic int exp_ones();
      int sum = 0;
      int first = m_t0 + D + m_S + 1;
      for (int k = first; k < first + (1 << m_W); k++) sum += smp(k);
      return sum;
   endfunction

   // Applies the clock edge that closes cycle cyc to the model.
   task automatic model_edge();
      if (!m_busy) begin
         if (start) begin
            m_busy = 1'b1;
            m_t0   = cyc;
            m_S    = int'(settle_cycles);
            m_W    = (int'(win_log2) > MAXW) ? MAXW : int'(win_log2);
         end
      end else if (exp_valid() && res_ready) begin
         $display("result seq=%0d ones=%0d W=%0d S=%0d start_cycle=%0d",
                  m_seq, exp_ones(), m_W, m_S, m_t0);
         m_busy = 1'b0;
         m_seq  = (m_seq + 1) % (1 << SW);
      end
   endtask

   task automatic compare_all();
      chk("busy", int'(busy), int'(m_busy));
      chk("res_valid", int'(res_valid), int'(exp_valid()));
      chk("overrun", int'(overrun), int'(start && m_busy));
      chk("res_seq", int'(res_seq), m_seq);
      if (exp_valid()) begin
         chk("res_ones", int'(res_ones), exp_ones());
         chk("res_win_log2", int'(res_win_log2), m_W);
      end
   endtask

   // One cycle: close the previous cycle, drive new inputs, check outputs.
   task automatic step(input bit st, input bit cm, input int s, input int w,
                       input bit rdy);
      @(posedge clk);
      if (have_prev) model_edge();
      @(negedge clk);
      start         = st;
      cmp_in        = cm;
      settle_cycles = 16'(s);
      win_log2      = 5'(w);
      res_ready     = rdy;
      cyc++;
      hist[cyc]     = cm;
      have_prev     = 1'b1;
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      start     = 1'b0;
      cmp_in    = 1'b0;
      res_ready = 1'b0;
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_res_valid", int'(res_valid), 0);
      chk("rst_res_seq", int'(res_seq), 0);
      chk("rst_res_ones", int'(res_ones), 0);
      chk("rst_res_win_log2", int'(res_win_log2), 0);
      chk("rst_overrun", int'(overrun), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n     = 1'b1;
      m_busy    = 1'b0;
      m_seq     = 0;
      have_prev = 1'b0;
      rst_cycle = cyc + 1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n         = 1'b0;
      start         = 1'b0;
      cmp_in        = 1'b0;
      settle_cycles = '0;
      win_log2      = '0;
      res_ready     = 1'b0;
      do_reset();

      // Constant ones, S=0, W=4: valid at 17 (+D), 16 ones, handshake bumps seq.
      step(1, 1, 0, 4, 0);
      for (int i = 1; i <= 17 + D; i++) begin
         step(0, 1, 0, 0, i == 17 + D);
         if (i == 16 + D) chk("t1_valid_early", int'(res_valid), 0);
         if (i == 17 + D) begin
            chk("t1_valid", int'(res_valid), 1);
            chk("t1_ones", int'(res_ones), 16);
            chk("t1_win", int'(res_win_log2), 4);
            chk("t1_seq", int'(res_seq), 0);
         end
      end
      step(0, 0, 0, 0, 0);
      chk("t1_seq_after", int'(res_seq), 1);
      chk("t1_valid_after", int'(res_valid), 0);

      // Toggling comparator, S=5, W=3: 4 ones, valid at 14 (+D).
      step(1, 1, 5, 3, 0);
      for (int i = 1; i <= 14 + D; i++) begin
         step(0, (i % 2) == 0, 0, 0, i == 14 + D);
`ifndef ETS_CMP_DEGLITCH_EN
         if (i == 13) chk("t2_valid_early", int'(res_valid), 0);
         if (i == 14) begin
            chk("t2_valid", int'(res_valid), 1);
            chk("t2_ones", int'(res_ones), 4);
         end
`endif
      end

      // Long HOLD with a start in the middle and one on the handshake cycle.
      step(1, 1, 1, 1, 0);
      for (int i = 1; i < 4 + D; i++) step(0, 1, 0, 0, 0);
      for (int j = 0; j < 10; j++) begin
         step(j == 4, 0, 7, 2, 0);
         chk("t3_hold_valid", int'(res_valid), 1);
         chk("t3_hold_ones", int'(res_ones), 2);
         if (j == 4) chk("t3_overrun", int'(overrun), 1);
         if (j == 5) chk("t3_overrun_gone", int'(overrun), 0);
      end
      step(1, 0, 0, 0, 1);
      chk("t3_overrun_hs", int'(overrun), 1);
      step(0, 0, 0, 0, 0);
      chk("t3_no_restart", int'(busy), 0);

      // Oversized exponent clamps to MAXW.
      step(1, 1, 0, 31, 0);
      for (int i = 1; i <= 33 + D; i++) begin
         step(0, 1, 0, 0, i == 33 + D);
         if (i == 33 + D) begin
            chk("t4_valid", int'(res_valid), 1);
            chk("t4_win", int'(res_win_log2), MAXW);
            chk("t4_ones", int'(res_ones), 32);
         end
      end

      // Reset in the middle of a window, then a fresh all-zero window.
      step(1, 1, 0, 4, 0);
      for (int i = 1; i <= 3 + D; i++) step(0, 1, 0, 0, 0);
      chk("t5_busy_before", int'(busy), 1);
      do_reset();
      step(1, 0, 0, 2, 0);
      for (int i = 1; i <= 5 + D; i++) begin
         step(0, 0, 0, 0, i == 5 + D);
         if (i == 5 + D) begin
            chk("t5_valid", int'(res_valid), 1);
            chk("t5_ones", int'(res_ones), 0);
            chk("t5_seq", int'(res_seq), 0);
         end
      end

`ifdef ETS_CMP_DEGLITCH_EN
      // Isolated single-cycle zeros are voted out: S=2, W=5, valid at S+35.
      step(1, 1, 2, 5, 0);
      for (int i = 1; i <= 37; i++) begin
         step(0, (i % 5) != 2, 0, 0, i == 37);
         if (i == 36) chk("dg_valid_early", int'(res_valid), 0);
         if (i == 37) begin
            chk("dg_valid", int'(res_valid), 1);
            chk("dg_ones", int'(res_ones), 32);
         end
      end
`endif

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 4000; n++) begin
         bit st;
         bit cm;
         bit rdy;
         int s;
         int w;
         if ($urandom_range(0, 799) == 0) do_reset();
         st  = ($urandom_range(0, 9) == 0);
         cm  = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 2) == 0);
         s   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40)
                                           : $urandom_range(0, 4);
         w   = ($urandom_range(0, 7) == 0) ? $urandom_range(6, 31)
                                           : $urandom_range(0, 5);
         step(st, cm, s, w, rdy);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
